des_block_scheduler: RTL

//  Job scheduler for an array of NUM_BLOCKS des_block instances sharing one seed/polynomial bus.
//  - Accepts (seed, polynomial) jobs over a valid/ready handshake.
//  - Dispatches each job round-robin to an idle block.
//  - Collects each finished block's mask counter through a one-entry result register, then restarts that block.
//  - Sits between the host/config wrapper and the des_block array.

---
 rtl/des_block_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/des_block_scheduler.sv
// des_block_scheduler: round-robin job dispatch to NUM_BLOCKS des_block instances and one-entry result collection.
// Define DES_SCHED_ACCUM_EN to add a saturating accumulator (total_clear/total_count) of popped result counts.
`timescale 1ns/1ps
module des_block_scheduler #(
    parameter int NUM_BLOCKS = 4,
    parameter int N          = 32,
    parameter int IDW        = 2,
    localparam int CW        = 64 - N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [63:0]              job_seed,
    input  logic [63:0]              job_polynomial,
    output logic [63:0]              blk_seed,
    output logic [63:0]              blk_polynomial,
    output logic [NUM_BLOCKS-1:0]    blk_start,
    output logic [NUM_BLOCKS-1:0]    blk_restart,
    input  logic [NUM_BLOCKS-1:0]    blk_done,
    input  logic [NUM_BLOCKS*CW-1:0] blk_counter,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [CW-1:0]            result_count,
    output logic [IDW-1:0]           result_id,
    output logic [IDW:0]             active_count
`ifdef DES_SCHED_ACCUM_EN
    ,
    input  logic                     total_clear,
    output logic [CW+7:0]            total_count
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends on valid, and an offer may be held for any number of cycles.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } blk_state_e;

    // Per-block FSM state, kept as a named array so checkers can bind to it.
    blk_state_e     state_q [NUM_BLOCKS];
    blk_state_e     state_d [NUM_BLOCKS];

    logic [IDW-1:0] disp_ptr;
    logic [IDW-1:0] coll_ptr;
    logic [IDW-1:0] disp_tgt;
    logic [IDW-1:0] coll_tgt;
    logic           disp_found;
    logic           coll_found;
    logic           accept;
    logic           cap_en;
    logic           pop;
    logic [IDW:0]   active_d;

    function automatic int wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_BLOCKS) s = s - NUM_BLOCKS;
        return s;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        if (int'(v) == NUM_BLOCKS - 1) return '0;
        return v + IDW'(1);
    endfunction

    // Round-robin search: first IDLE block for dispatch, first finished BUSY block for capture.
    always_comb begin
        disp_found = 1'b0;
        disp_tgt   = '0;
        coll_found = 1'b0;
        coll_tgt   = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (!disp_found && state_q[wrap_add(disp_ptr, k)] == ST_IDLE) begin
                disp_found = 1'b1;
                disp_tgt   = IDW'(wrap_add(disp_ptr, k));
            end
            if (!coll_found && state_q[wrap_add(coll_ptr, k)] == ST_BUSY
                && blk_done[wrap_add(coll_ptr, k)]) begin
                coll_found = 1'b1;
                coll_tgt   = IDW'(wrap_add(coll_ptr, k));
            end
        end
    end

    assign job_ready = disp_found;
    assign accept    = job_valid & disp_found;
    assign pop       = result_valid & result_ready;
    assign cap_en    = (!result_valid | result_ready) & coll_found;

    always_comb begin
        active_d = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == ST_RELEASE) state_d[i] = ST_IDLE;
            if (accept && int'(disp_tgt) == i) state_d[i] = ST_BUSY;
            if (cap_en && int'(coll_tgt) == i) state_d[i] = ST_RELEASE;
            if (state_d[i] != ST_IDLE) active_d = active_d + (IDW+1)'(1);
        end
    end

    // The restart pulse is the RELEASE state itself, so an async reset drops it at once.
    always_comb begin
        blk_restart = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            blk_restart[i] = (state_q[i] == ST_RELEASE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) state_q[i] <= ST_IDLE;
            disp_ptr       <= '0;
            coll_ptr       <= '0;
            blk_seed       <= '0;
            blk_polynomial <= '0;
            blk_start      <= '0;
            result_valid   <= 1'b0;
            result_count   <= '0;
            result_id      <= '0;
            active_count   <= '0;
        end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) state_q[i] <= state_d[i];
            active_count <= active_d;
            blk_start    <= accept ? (NUM_BLOCKS'(1) << disp_tgt) : '0;
            if (accept) begin
                blk_seed       <= job_seed;
                blk_polynomial <= job_polynomial;
                disp_ptr       <= wrap_inc(disp_tgt);
            end
            if (cap_en) begin
                result_count <= blk_counter[int'(coll_tgt)*CW +: CW];
                result_id    <= coll_tgt;
                result_valid <= 1'b1;
                coll_ptr     <= wrap_inc(coll_tgt);
            end else if (pop) begin
                result_valid <= 1'b0;
            end
        end
    end

`ifdef DES_SCHED_ACCUM_EN
    localparam int TW = CW + 8;
    logic [TW:0] acc_sum;

    assign acc_sum = {1'b0, total_count} + (TW+1)'(result_count);

    // A clear coinciding with a pop restarts the total from the popped count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
        end else if (total_clear) begin
            total_count <= pop ? TW'(result_count) : '0;
        end else if (pop) begin
            total_count <= acc_sum[TW] ? '1 : acc_sum[TW-1:0];
        end
    end
`endif

endmodule
